// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared widths, types, ULA opcodes and helpers for the MIPS
//            operand stage.
// Revision : 1.0
// ============================================================================
package mips_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam int OP_W     = 4;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [OP_W-1:0]   ula_op_t;

    localparam ula_op_t ULA_AND  = 4'b0000;
    localparam ula_op_t ULA_OR   = 4'b0001;
    localparam ula_op_t ULA_ADD  = 4'b0010;
    localparam ula_op_t ULA_ADDU = 4'b0011;
    localparam ula_op_t ULA_SUB  = 4'b0100;
    localparam ula_op_t ULA_SUBU = 4'b0101;
    localparam ula_op_t ULA_SLT  = 4'b0110;
    localparam ula_op_t ULA_SLTU = 4'b0111;

    localparam addr_t REG_ZERO = '0;

    function automatic data_t sign_ext16(input logic [15:0] v);
        return {{(DATA_W-16){v[15]}}, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_operand_stage_if
// Brief    : Decode-side, write-back and ULA-side signals of the operand stage.
// Revision : 1.0
// ============================================================================
interface mips_operand_stage_if;
    import mips_pkg::*;

    logic    in_valid;
    logic    in_ready;
    addr_t   rs_addr;
    addr_t   rt_addr;
    logic [15:0] imm;
    logic    use_imm;
    ula_op_t ula_op_in;
    logic    flush;
    logic    wr_en;
    addr_t   wr_addr;
    data_t   wr_data;
    logic    out_valid;
    logic    out_ready;
    data_t   A;
    data_t   B;
    ula_op_t ULAopcode;

    modport master (
        output in_valid, rs_addr, rt_addr, imm, use_imm, ula_op_in, flush,
               wr_en, wr_addr, wr_data, out_ready,
        input  in_ready, out_valid, A, B, ULAopcode
    );

    modport slave (
        input  in_valid, rs_addr, rt_addr, imm, use_imm, ula_op_in, flush,
               wr_en, wr_addr, wr_data, out_ready,
        output in_ready, out_valid, A, B, ULAopcode
    );

endinterface
`default_nettype wire

// File: rtl/mips_regfile.sv
`default_nettype none
// ============================================================================
// Module   : mips_regfile
// Brief    : 32x32 2R/1W register file, reg[0] hard zero, write-through reads.
// Revision : 1.0
// ============================================================================
module mips_regfile
    import mips_pkg::*;
(
    input  wire logic  clock,
    input  wire logic  reset,
    input  wire addr_t rd_addr_a_i,
    input  wire addr_t rd_addr_b_i,
    output data_t      rd_data_a_o,
    output data_t      rd_data_b_o,
    input  wire logic  wr_en_i,
    input  wire addr_t wr_addr_i,
    input  wire data_t wr_data_i
);

    data_t mem_q [NUM_REGS];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i && (wr_addr_i != REG_ZERO)) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // A write in flight is forwarded so decode sees it in the same cycle.
    always_comb begin
        rd_data_a_o = '0;
        rd_data_b_o = '0;
        if (rd_addr_a_i != REG_ZERO) begin
            rd_data_a_o = (wr_en_i && (wr_addr_i == rd_addr_a_i)) ? wr_data_i : mem_q[rd_addr_a_i];
        end
        if (rd_addr_b_i != REG_ZERO) begin
            rd_data_b_o = (wr_en_i && (wr_addr_i == rd_addr_b_i)) ? wr_data_i : mem_q[rd_addr_b_i];
        end
    end

endmodule
`default_nettype wire

// File: rtl/mips_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : mips_operand_stage
// Brief    : Operand fetch for the ULA with a one-entry ID/EX valid/ready buffer.
// Revision : 1.0
// ============================================================================
module mips_operand_stage
    import mips_pkg::*;
(
    input  wire logic          clock,
    input  wire logic          reset,
    mips_operand_stage_if.slave bus
);

    data_t   w_rd_a;
    data_t   w_rd_b;
    logic    w_in_ready;
    logic    w_accept;

    logic    out_valid_q, out_valid_d;
    data_t   a_q, a_d;
    data_t   b_q, b_d;
    ula_op_t op_q, op_d;
    addr_t   rs_q, rs_d;
    addr_t   rt_q, rt_d;
    logic    use_imm_q, use_imm_d;

    mips_regfile u_regfile (
        .clock       (clock),
        .reset       (reset),
        .rd_addr_a_i (bus.rs_addr),
        .rd_addr_b_i (bus.rt_addr),
        .rd_data_a_o (w_rd_a),
        .rd_data_b_o (w_rd_b),
        .wr_en_i     (bus.wr_en),
        .wr_addr_i   (bus.wr_addr),
        .wr_data_i   (bus.wr_data)
    );

    assign w_in_ready = !bus.flush && (!out_valid_q || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        use_imm_d   = use_imm_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (w_accept) begin
            out_valid_d = 1'b1;
            a_d         = w_rd_a;
            b_d         = bus.use_imm ? sign_ext16(bus.imm) : w_rd_b;
            op_d        = bus.ula_op_in;
            rs_d        = bus.rs_addr;
            rt_d        = bus.rt_addr;
            use_imm_d   = bus.use_imm;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end else if (out_valid_q) begin
            // Held entry tracks late write-backs to its source registers.
            if (bus.wr_en && (bus.wr_addr == rs_q) && (rs_q != REG_ZERO)) begin
                a_d = bus.wr_data;
            end
            if (bus.wr_en && (bus.wr_addr == rt_q) && (rt_q != REG_ZERO) && !use_imm_q) begin
                b_d = bus.wr_data;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= ULA_AND;
            rs_q        <= REG_ZERO;
            rt_q        <= REG_ZERO;
            use_imm_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            use_imm_q   <= use_imm_d;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.A         = a_q;
    assign bus.B         = b_q;
    assign bus.ULAopcode = op_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_operand_stage
// Brief    : Directed self-checking bench for the MIPS operand stage.
// Revision : 1.0
// ============================================================================
module tb_mips_operand_stage;
    import mips_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mips_operand_stage_if bus ();

    mips_operand_stage dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.rs_addr   = '0;
        bus.rt_addr   = '0;
        bus.imm       = '0;
        bus.use_imm   = 1'b0;
        bus.ula_op_in = '0;
        bus.flush     = 1'b0;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.out_ready = 1'b1;
    endtask

    task automatic write_reg(input addr_t a, input data_t d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic issue(input addr_t rs, input addr_t rt, input logic ui,
                         input logic [15:0] im, input ula_op_t op);
        bus.in_valid  = 1'b1;
        bus.rs_addr   = rs;
        bus.rt_addr   = rt;
        bus.use_imm   = ui;
        bus.imm       = im;
        bus.ula_op_in = op;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.A !== 32'h0) begin errors++; $display("FAIL reset_A: got %h expected 00000000", bus.A); end
        checks++; if (bus.B !== 32'h0) begin errors++; $display("FAIL reset_B: got %h expected 00000000", bus.B); end
        checks++; if (bus.ULAopcode !== 4'b0000) begin errors++; $display("FAIL reset_op: got %b expected 0000", bus.ULAopcode); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_read();
        write_reg(5'd5, 32'h0000_1234);
        issue(5'd5, 5'd0, 1'b0, 16'h0, ULA_ADD);
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL read_valid: got %b expected 1", bus.out_valid); end
        checks++; if (bus.A !== 32'h0000_1234) begin errors++; $display("FAIL read_A: got %h expected 00001234", bus.A); end
        checks++; if (bus.B !== 32'h0) begin errors++; $display("FAIL read_B: got %h expected 00000000", bus.B); end
        checks++; if (bus.ULAopcode !== ULA_ADD) begin errors++; $display("FAIL read_op: got %b expected 0010", bus.ULAopcode); end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL read_drain: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_bypass();
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd7;
        bus.wr_data = 32'hDEAD_BEEF;
        issue(5'd7, 5'd0, 1'b0, 16'h0, ULA_OR);
        step();
        checks++; if (bus.A !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_A: got %h expected deadbeef", bus.A); end
        bus.wr_data = 32'h0000_0042;
        bus.wr_addr = 5'd9;
        issue(5'd5, 5'd9, 1'b0, 16'h0, ULA_OR);
        step();
        checks++; if (bus.B !== 32'h0000_0042) begin errors++; $display("FAIL bypass_B: got %h expected 00000042", bus.B); end
        bus.wr_addr = 5'd0;
        bus.wr_data = 32'hFFFF_FFFF;
        issue(5'd0, 5'd7, 1'b0, 16'h0, ULA_OR);
        step();
        checks++; if (bus.A !== 32'h0) begin errors++; $display("FAIL bypass_r0: got %h expected 00000000", bus.A); end
        checks++; if (bus.B !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stored_r7: got %h expected deadbeef", bus.B); end
        bus.wr_en = 1'b0;
        issue(5'd0, 5'd0, 1'b0, 16'h0, ULA_OR);
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.A !== 32'h0) begin errors++; $display("FAIL read_r0: got %h expected 00000000", bus.A); end
        step();
    endtask

    task automatic test_imm();
        issue(5'd5, 5'd5, 1'b1, 16'h8001, ULA_SLT);
        step();
        checks++; if (bus.B !== 32'hFFFF_8001) begin errors++; $display("FAIL imm_neg: got %h expected ffff8001", bus.B); end
        checks++; if (bus.ULAopcode !== ULA_SLT) begin errors++; $display("FAIL imm_op: got %b expected 0110", bus.ULAopcode); end
        issue(5'd5, 5'd5, 1'b1, 16'h7FFF, ULA_SLTU);
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.B !== 32'h0000_7FFF) begin errors++; $display("FAIL imm_pos: got %h expected 00007fff", bus.B); end
        step();
    endtask

    task automatic test_refresh();
        write_reg(5'd3, 32'h33);
        write_reg(5'd4, 32'h44);
        bus.out_ready = 1'b0;
        issue(5'd3, 5'd4, 1'b0, 16'h0, ULA_SUB);
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.A !== 32'h33 || bus.B !== 32'h44) begin errors++; $display("FAIL hold_load: got A=%h B=%h expected A=00000033 B=00000044", bus.A, bus.B); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready: got %b expected 0", bus.in_ready); end
        write_reg(5'd4, 32'h55);
        checks++; if (bus.B !== 32'h55) begin errors++; $display("FAIL refresh_B: got %h expected 00000055", bus.B); end
        checks++; if (bus.A !== 32'h33) begin errors++; $display("FAIL refresh_A_keep: got %h expected 00000033", bus.A); end
        checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL refresh_hs: got v=%b r=%b expected v=1 r=0", bus.out_valid, bus.in_ready); end
        write_reg(5'd3, 32'h66);
        checks++; if (bus.A !== 32'h66) begin errors++; $display("FAIL refresh_A: got %h expected 00000066", bus.A); end
        // A new instruction offered during hold must not displace the entry.
        issue(5'd5, 5'd5, 1'b0, 16'h0, ULA_AND);
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.A !== 32'h66 || bus.ULAopcode !== ULA_SUB) begin errors++; $display("FAIL hold_stable: got A=%h op=%b expected A=00000066 op=0100", bus.A, bus.ULAopcode); end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        issue(5'd3, 5'd4, 1'b1, 16'h0010, ULA_SUBU);
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.A !== 32'h66 || bus.B !== 32'h10) begin errors++; $display("FAIL hold_imm_load: got A=%h B=%h expected A=00000066 B=00000010", bus.A, bus.B); end
        write_reg(5'd4, 32'h77);
        checks++; if (bus.B !== 32'h10) begin errors++; $display("FAIL refresh_imm_B: got %h expected 00000010", bus.B); end
        write_reg(5'd3, 32'h99);
        checks++; if (bus.A !== 32'h99) begin errors++; $display("FAIL refresh_imm_A: got %h expected 00000099", bus.A); end
        bus.out_ready = 1'b1;
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL hold_drain: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        ula_op_t ops [4];
        ops[0] = ULA_ADDU; ops[1] = ULA_SUB; ops[2] = ULA_OR; ops[3] = ULA_AND;
        for (int i = 0; i < 4; i++) begin
            write_reg(addr_t'(8 + i), 32'h100 + i);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(addr_t'(8 + i), 5'd0, 1'b1, 16'(i), ops[i]);
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, bus.in_ready); end
            step();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.A !== 32'h100 + i || bus.B !== 32'(i) || bus.ULAopcode !== ops[i]) begin
                errors++;
                $display("FAIL b2b_out[%0d]: got v=%b A=%h B=%h op=%b expected v=1 A=%h B=%h op=%b",
                         i, bus.out_valid, bus.A, bus.B, bus.ULAopcode, 32'h100 + i, 32'(i), ops[i]);
            end
        end
        bus.in_valid = 1'b0;
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        issue(5'd8, 5'd0, 1'b0, 16'h0, ULA_ADD);
        step();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL flush_pre: got %b expected 1", bus.out_valid); end
        issue(5'd9, 5'd0, 1'b0, 16'h0, ULA_SLT);
        bus.flush   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd12;
        bus.wr_data = 32'hABC;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b expected 0", bus.in_ready); end
        step();
        bus.flush    = 1'b0;
        bus.wr_en    = 1'b0;
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", bus.out_valid); end
        bus.out_ready = 1'b1;
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped: got %b expected 0", bus.out_valid); end
        issue(5'd12, 5'd0, 1'b0, 16'h0, ULA_ADD);
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.A !== 32'hABC) begin errors++; $display("FAIL flush_write: got %h expected 00000abc", bus.A); end
        step();
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        issue(5'd8, 5'd8, 1'b0, 16'h0, ULA_SUBU);
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.A !== 32'h100) begin errors++; $display("FAIL areset_pre: got v=%b A=%h expected v=1 A=00000100", bus.out_valid, bus.A); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.A !== 32'h0 || bus.B !== 32'h0 || bus.ULAopcode !== 4'b0000) begin
            errors++;
            $display("FAIL areset_now: got v=%b A=%h B=%h op=%b expected all zero", bus.out_valid, bus.A, bus.B, bus.ULAopcode);
        end
        step();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        issue(5'd8, 5'd12, 1'b0, 16'h0, ULA_ADD);
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.A !== 32'h0 || bus.B !== 32'h0) begin errors++; $display("FAIL areset_rf: got A=%h B=%h expected 0", bus.A, bus.B); end
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle_inputs();
        test_reset();
        test_read();
        test_bypass();
        test_imm();
        test_refresh();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
